// File: rtl/election_pkg.sv
// election_pkg: FSM state encoding and count-width helper for election_ctrl.
package election_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_TALLY = 2'd2,
    S_DONE  = 2'd3
  } state_t;
  function automatic int cw(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/vote_tally.sv
// vote_tally: combinational popcount of accepted yes ballots and of cast ballots, plus strict-majority compare.
module vote_tally #(
  parameter int N_VOTERS = 7,
  parameter int CW = 3
) (
  input  logic [N_VOTERS-1:0] i_ballot,
  input  logic [N_VOTERS-1:0] i_voted,
  output logic [CW-1:0]       o_yes,
  output logic [CW-1:0]       o_cast,
  output logic                o_majority
);
  always_comb begin
    o_yes = '0;
    o_cast = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      o_yes = o_yes + CW'(i_ballot[i] & i_voted[i]);
      o_cast = o_cast + CW'(i_voted[i]);
    end
    o_majority = int'(o_yes) > N_VOTERS / 2;
  end
endmodule

// File: rtl/election_ctrl.sv
// election_ctrl: timed single-ballot voting session with strict-majority result.
// Define ELECTION_QUORUM_EN to force result=0 and raise no_quorum when fewer than QUORUM ballots are cast.
module election_ctrl
  import election_pkg::*;
#(
  parameter int N_VOTERS = 7,
  parameter int WINDOW = 16,
  parameter int QUORUM = 4,
  localparam int CW = cw(N_VOTERS),
  localparam int TW = $clog2(WINDOW + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic [N_VOTERS-1:0] voted,
  output logic                busy,
  output logic                result_valid,
  output logic                result,
  output logic [CW-1:0]       yes_count,
  output logic [CW-1:0]       cast_count,
  output logic                no_quorum
);
  state_t              r_state;
  logic [N_VOTERS-1:0] r_voted, r_ballot;
  logic [TW-1:0]       r_timer;
  logic                r_busy, r_valid, r_result, r_nq;
  logic [CW-1:0]       r_yes, r_cast;
  logic [N_VOTERS-1:0] w_acc, w_voted_nxt;
  logic [CW-1:0]       w_yes, w_cast;
  logic                w_maj;
  assign w_acc = vote_valid & ~r_voted;
  assign w_voted_nxt = r_voted | w_acc;
  vote_tally #(.N_VOTERS(N_VOTERS), .CW(CW)) u_tally (
    .i_ballot(r_ballot),
    .i_voted(r_voted),
    .o_yes(w_yes),
    .o_cast(w_cast),
    .o_majority(w_maj)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_voted <= '0;
      r_ballot <= '0;
      r_timer <= '0;
      r_busy <= 1'b0;
      r_valid <= 1'b0;
      r_result <= 1'b0;
      r_nq <= 1'b0;
      r_yes <= '0;
      r_cast <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_voted <= '0;
          r_ballot <= '0;
          r_timer <= TW'(WINDOW - 1);
          r_busy <= 1'b1;
          r_result <= 1'b0;
          r_nq <= 1'b0;
          r_yes <= '0;
          r_cast <= '0;
          r_state <= S_OPEN;
        end
        S_OPEN: begin
          r_voted <= w_voted_nxt;
          r_ballot <= (r_ballot & ~w_acc) | (w_acc & vote_yes);
          if (r_timer == '0 || &w_voted_nxt) r_state <= S_TALLY;
          else r_timer <= r_timer - 1'b1;
        end
        S_TALLY: begin
          r_yes <= w_yes;
          r_cast <= w_cast;
`ifdef ELECTION_QUORUM_EN
          r_nq <= int'(w_cast) < QUORUM;
          r_result <= w_maj && !(int'(w_cast) < QUORUM);
`else
          r_result <= w_maj;
`endif
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign voted = r_voted;
  assign busy = r_busy;
  assign result_valid = r_valid;
  assign result = r_result;
  assign yes_count = r_yes;
  assign cast_count = r_cast;
  assign no_quorum = r_nq;
endmodule

// File: tb/tb_election_ctrl.sv
// tb_election_ctrl: directed self-checking bench for election_ctrl (N_VOTERS=7, WINDOW=16, QUORUM=4).
module tb_election_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] vote_valid = '0;
  logic [6:0] vote_yes = '0;
  logic [6:0] voted;
  logic       busy, result_valid, result, no_quorum;
  logic [2:0] yes_count, cast_count;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n;
  logic       seen;
  election_ctrl #(.N_VOTERS(7), .WINDOW(16), .QUORUM(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .vote_valid(vote_valid),
    .vote_yes(vote_yes),
    .voted(voted),
    .busy(busy),
    .result_valid(result_valid),
    .result(result),
    .yes_count(yes_count),
    .cast_count(cast_count),
    .no_quorum(no_quorum)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_result(input string tag);
    n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(result_valid), 1);
  endtask
  task automatic open_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b1;
    vote_valid = '1;
    vote_yes = '1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_voted", 32'(voted), 0);
    check("rst_result", 32'(result), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_yes", 32'(yes_count), 0);
    check("rst_cast", 32'(cast_count), 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("idle_vote_ignored", 32'(voted), 0);
    check("idle_busy", 32'(busy), 0);
    vote_valid = '0;
    open_session();
    check("maj_busy", 32'(busy), 1);
    vote_valid = '1;
    vote_yes = 7'b0001111;
    tick();
    vote_valid = '0;
    check("maj_tally_novalid", 32'(result_valid), 0);
    tick();
    check("maj_valid", 32'(result_valid), 1);
    check("maj_yes", 32'(yes_count), 4);
    check("maj_cast", 32'(cast_count), 7);
    check("maj_result", 32'(result), 1);
    check("maj_voted", 32'(voted), 32'h7f);
    tick();
    check("maj_pulse_end", 32'(result_valid), 0);
    check("maj_idle_busy", 32'(busy), 0);
    check("maj_hold", 32'(result), 1);
    open_session();
    vote_valid = '1;
    vote_yes = 7'b0000111;
    tick();
    vote_valid = '0;
    tick();
    check("min_valid", 32'(result_valid), 1);
    check("min_yes", 32'(yes_count), 3);
    check("min_result", 32'(result), 0);
    tick();
    tick();
    tick();
    check("min_hold", 32'(result), 0);
    check("min_hold_yes", 32'(yes_count), 3);
    open_session();
    vote_valid = 7'b0000001;
    vote_yes = 7'b0000001;
    tick();
    vote_yes = 7'b0000000;
    tick();
    vote_valid = '0;
    wait_result("dup");
    check("dup_window", 32'(n + 2), 17);
    check("dup_cast", 32'(cast_count), 1);
    check("dup_yes", 32'(yes_count), 1);
    check("dup_result", 32'(result), 0);
    tick();
    open_session();
    vote_valid = 7'b0000111;
    vote_yes = '1;
    tick();
    vote_valid = '0;
    wait_result("quo");
    check("quo_yes", 32'(yes_count), 3);
    check("quo_cast", 32'(cast_count), 3);
    check("quo_result", 32'(result), 0);
`ifdef ELECTION_QUORUM_EN
    check("quo_flag", 32'(no_quorum), 1);
`else
    check("quo_flag", 32'(no_quorum), 0);
`endif
    tick();
    open_session();
    vote_valid = 7'b0011111;
    vote_yes = '1;
    tick();
    vote_valid = '0;
    check("mid_voted", 32'(voted), 32'h1f);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 32'(busy), 0);
    check("mid_voted_clr", 32'(voted), 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen = seen | result_valid;
      tick();
    end
    check("mid_no_valid", 32'(seen), 0);
    open_session();
    vote_valid = 7'b0001111;
    vote_yes = '1;
    tick();
    vote_valid = '0;
    wait_result("new");
    check("new_result", 32'(result), 1);
    check("new_cast", 32'(cast_count), 4);
    check("new_yes", 32'(yes_count), 4);
    check("new_nq", 32'(no_quorum), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
